modsub_stream: RTL and testbench

- Streaming pipelined modular subtractor: C = (A - B) mod q, with A and B in [0, q).
- q uses the team's special modulus form: q = (qH << W) | 1 truncated to LOGQ bits (W = LOGQ - LOGQH); q = qH when LOGQ == LOGQH.
- Inverse operation of the modular adder. Used in NTT butterfly and INTT datapaths where the lower lane needs (a - b) mod q.
- Adds a valid/ready elastic pipeline with backpressure and a sideband tag so it can sit in stallable datapaths.

---
 rtl/modsub_stream_pkg.sv | 38 +++
 rtl/modsub_stream_if.sv | 28 ++
 rtl/modsub_stream_elastic_reg.sv | 32 +++
 rtl/modsub_stream.sv | 116 +++++++++++
 tb/tb_modsub_stream.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/modsub_stream_pkg.sv
// Shared definitions for the modular add/sub datapath blocks: parameter
// bundle, pipeline latency helper and special-form modulus construction.
package modsub_stream_pkg;

  // Widest modulus the helper functions handle; callers size-cast the result.
  localparam int MODSUB_MAXW = 128;

  typedef struct packed {
    int LOGQ;
    int LOGQH;
    int FF_IN;
    int FF_SUB;
    int FF_OUT;
  } modsub_params_t;

  // Number of enabled register stages, i.e. accept-to-valid latency.
  function automatic int modsub_lat(input modsub_params_t p);
    return ((p.FF_IN  != 0) ? 1 : 0) +
           ((p.FF_SUB != 0) ? 1 : 0) +
           ((p.FF_OUT != 0) ? 1 : 0);
  endfunction

  // q = (qH << (LOGQ-LOGQH)) | 1, truncated to LOGQ bits; q = qH when the
  // widths are equal.
  function automatic logic [MODSUB_MAXW-1:0] make_q(
    input logic [MODSUB_MAXW-1:0] qh,
    input int                     logq,
    input int                     logqh
  );
    logic [MODSUB_MAXW-1:0] q;
    logic [MODSUB_MAXW-1:0] mask;
    if (logq == logqh) q = qh;
    else               q = (qh << (logq - logqh)) | MODSUB_MAXW'(1);
    mask = {MODSUB_MAXW{1'b1}} >> (MODSUB_MAXW - logq);
    return q & mask;
  endfunction

endpackage

// File: rtl/modsub_stream_if.sv
// Operand/result stream bundle for modsub_stream. The master side feeds
// operands and accepts results; the slave side is the subtractor.
interface modsub_stream_if #(
  parameter int LOGQ  = 64,
  parameter int LOGQH = 47,
  parameter int TAGW  = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [LOGQ-1:0]  A;
  logic [LOGQ-1:0]  B;
  logic [LOGQH-1:0] qH;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [LOGQ-1:0]  C;
  logic [TAGW-1:0]  out_tag;

  modport master (
    output in_valid, A, B, qH, in_tag, out_ready,
    input  in_ready, out_valid, C, out_tag
  );

  modport slave (
    input  in_valid, A, B, qH, in_tag, out_ready,
    output in_ready, out_valid, C, out_tag
  );
endinterface

// File: rtl/modsub_stream_elastic_reg.sv
// One valid/ready register slice. An empty slice always accepts, so bubbles
// collapse; a full slice holds its payload until downstream takes it.
module elastic_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         vld;
  logic [W-1:0] data;

  assign in_ready  = !vld || out_ready;
  assign out_valid = vld;
  assign out_data  = data;

  // Valid bit: cleared asynchronously, reloaded whenever the slice may load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        vld <= 1'b0;
    else if (in_ready) vld <= in_valid;
  end

  // Payload: captured only on an actual transfer, otherwise held.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) data <= in_data;
  end
endmodule

// File: rtl/modsub_stream.sv
// Streaming modular subtractor C = (A - B) mod q with an elastic
// valid/ready pipeline of up to three optional register stages.
module modsub_stream
  import modsub_stream_pkg::*;
#(
  parameter int LOGQ   = 64,
  parameter int LOGQH  = 47,
  parameter int FF_IN  = 1,
  parameter int FF_SUB = 1,
  parameter int FF_OUT = 1,
  parameter int TAGW   = 8
) (
  input logic            clk,
  input logic            rst_n,
  modsub_stream_if.slave bus
);
  localparam modsub_params_t P = '{LOGQ, LOGQH, FF_IN, FF_SUB, FF_OUT};
  localparam int LAT = modsub_lat(P);
  localparam int W0  = 2*LOGQ + LOGQH + TAGW;
  localparam int W1  = (LOGQ + 1) + LOGQ + TAGW;
  localparam int W2  = LOGQ + TAGW;

  // Negative raw difference is fixed up by the pre-computed D + q.
  function automatic logic [LOGQ-1:0] mod_correct(
    input logic signed [LOGQ:0] d,
    input logic [LOGQ-1:0]      dq
  );
    return d[LOGQ] ? dq : d[LOGQ-1:0];
  endfunction

  // Per-stage accept (in_ready) signals; ready flows backwards.
  logic acc_s0, acc_s1, acc_s2;
  logic vld_p0, vld_p1, vld_p2;

  logic [W0-1:0] s0_in, s0_out;
  logic [W1-1:0] s1_in, s1_out;
  logic [W2-1:0] s2_in, s2_out;

  logic [LOGQ-1:0]         a_p0, b_p0;
  logic [LOGQH-1:0]        qh_p0;
  logic [TAGW-1:0]         tag_p0;
  logic [LOGQ-1:0]         q_c;
  logic signed [LOGQ:0]    d_c;
  logic [LOGQ-1:0]         dq_c;
  logic signed [LOGQ:0]    d_p1;
  logic [LOGQ-1:0]         dq_p1;
  logic [TAGW-1:0]         tag_p1;
  logic [LOGQ-1:0]         c_p2;
  logic [TAGW-1:0]         tag_p2;

  assign bus.in_ready = acc_s0;

  // ---- stage 0: operands, modulus high part and tag ----
  assign s0_in = {bus.A, bus.B, bus.qH, bus.in_tag};

  if (FF_IN != 0) begin : g_s0
    elastic_reg #(.W(W0)) u_reg (
      .clk(clk), .rst_n(rst_n),
      .in_valid(bus.in_valid), .in_ready(acc_s0), .in_data(s0_in),
      .out_valid(vld_p0), .out_ready(acc_s1), .out_data(s0_out)
    );
  end else begin : g_s0_byp
    assign vld_p0 = bus.in_valid;
    assign acc_s0 = acc_s1;
    assign s0_out = s0_in;
  end

  assign {a_p0, b_p0, qh_p0, tag_p0} = s0_out;

  assign q_c  = LOGQ'(make_q(MODSUB_MAXW'(qh_p0), LOGQ, LOGQH));
  assign d_c  = $signed({1'b0, a_p0}) - $signed({1'b0, b_p0});
  assign dq_c = LOGQ'(d_c + $signed({1'b0, q_c}));

  // ---- stage 1: raw difference and its q-corrected twin ----
  assign s1_in = {d_c, dq_c, tag_p0};

  if (FF_SUB != 0) begin : g_s1
    elastic_reg #(.W(W1)) u_reg (
      .clk(clk), .rst_n(rst_n),
      .in_valid(vld_p0), .in_ready(acc_s1), .in_data(s1_in),
      .out_valid(vld_p1), .out_ready(acc_s2), .out_data(s1_out)
    );
  end else begin : g_s1_byp
    assign vld_p1 = vld_p0;
    assign acc_s1 = acc_s2;
    assign s1_out = s1_in;
  end

  assign {d_p1, dq_p1, tag_p1} = s1_out;

  // ---- stage 2: selected result ----
  assign s2_in = {mod_correct(d_p1, dq_p1), tag_p1};

  if (FF_OUT != 0) begin : g_s2
    elastic_reg #(.W(W2)) u_reg (
      .clk(clk), .rst_n(rst_n),
      .in_valid(vld_p1), .in_ready(acc_s2), .in_data(s2_in),
      .out_valid(vld_p2), .out_ready(bus.out_ready), .out_data(s2_out)
    );
  end else begin : g_s2_byp
    assign vld_p2 = vld_p1;
    assign acc_s2 = bus.out_ready;
    assign s2_out = s2_in;
  end

  assign {c_p2, tag_p2} = s2_out;

  // Payload is forced to zero whenever no result is presented, which also
  // gives C = 0 / out_tag = 0 throughout reset without resetting data flops.
  assign bus.out_valid = vld_p2;
  assign bus.C         = vld_p2 ? c_p2   : '0;
  assign bus.out_tag   = vld_p2 ? tag_p2 : '0;

  if (LAT < 0) begin : g_never
  end
endmodule

// File: tb/tb_modsub_stream.sv
// Bench for modsub_stream: directed small-modulus tests, a combinational
// configuration and a randomised 64-bit run, all scoreboard checked.
module tb_modsub_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  modsub_stream_if #(.LOGQ(8),  .LOGQH(5),  .TAGW(8)) bus8  ();
  modsub_stream_if #(.LOGQ(8),  .LOGQH(5),  .TAGW(8)) bus0  ();
  modsub_stream_if #(.LOGQ(64), .LOGQH(47), .TAGW(8)) bus64 ();

  modsub_stream #(.LOGQ(8), .LOGQH(5), .FF_IN(1), .FF_SUB(1), .FF_OUT(1), .TAGW(8))
    dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  modsub_stream #(.LOGQ(8), .LOGQH(5), .FF_IN(0), .FF_SUB(0), .FF_OUT(0), .TAGW(8))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  modsub_stream #(.LOGQ(64), .LOGQH(47), .FF_IN(1), .FF_SUB(1), .FF_OUT(1), .TAGW(8))
    dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  typedef struct {
    logic [63:0] c;
    logic [7:0]  tag;
  } exp_t;

  exp_t q8[$];
  exp_t q64[$];
  int   out8_n  = 0;
  int   out64_n = 0;
  int   out8_cyc[$];
  int   acc8_cyc;
  int   sent64 = 0;
  bit   drv_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic on wide integers.
  function automatic logic [63:0] ref_mod(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] q);
    logic [127:0] s;
    s = {64'd0, a} + {64'd0, q} - {64'd0, b};
    return 64'(s % {64'd0, q});
  endfunction

  // Modulus of the special form, derived from its definition.
  function automatic logic [63:0] q_of(input logic [46:0] qh);
    logic [127:0] t;
    t = ({81'd0, qh} << 17) | 128'd1;
    return t[63:0];
  endfunction

  // Output monitors: every presented-and-taken result pops the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus8.out_valid && bus8.out_ready) begin
      out8_n++;
      out8_cyc.push_back(cyc);
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb8_extra: got result tag 0x%0h, expected no output", bus8.out_tag);
      end else begin
        e = q8.pop_front();
        chk("sb8_C",   64'(bus8.C),       e.c);
        chk("sb8_tag", 64'(bus8.out_tag), 64'(e.tag));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus64.out_valid && bus64.out_ready) begin
      out64_n++;
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb64_extra: got result tag 0x%0h, expected no output", bus64.out_tag);
      end else begin
        e = q64.pop_front();
        chk("sb64_C",   bus64.C,           e.c);
        chk("sb64_tag", 64'(bus64.out_tag), 64'(e.tag));
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] tag,
                       input logic [63:0] c_exp, output int waited);
    bus8.A = a; bus8.B = b; bus8.in_tag = tag; bus8.qH = 5'd15; bus8.in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus8.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!bus8.in_ready) begin
      checks++; errors++;
      $display("FAIL send8_timeout: in_ready got 0, expected 1 within 50 cycles");
    end else begin
      q8.push_back('{c_exp, tag});
      acc8_cyc = cyc;
    end
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic drain8(input string name);
    int n;
    n = 0;
    while (q8.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(q8.size()), 64'd0);
  endtask

  logic [7:0]  bp_a[5];
  logic [7:0]  bp_b[5];
  int          bp_idx;

  task automatic bp_step();
    @(negedge clk);
    if (bus8.in_valid && bus8.in_ready) begin
      q8.push_back('{ref_mod(64'(bp_a[bp_idx]), 64'(bp_b[bp_idx]), 64'd121),
                     8'hB0 + 8'(bp_idx)});
      bp_idx++;
    end
    @(posedge clk); #1;
    if (bp_idx < 5) begin
      bus8.A = bp_a[bp_idx]; bus8.B = bp_b[bp_idx];
      bus8.in_tag = 8'hB0 + 8'(bp_idx); bus8.in_valid = 1'b1;
    end else begin
      bus8.in_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n0;
    logic [7:0]  a8, b8;
    logic [46:0] qh;
    logic [63:0] q, a, b;

    bus8.in_valid = 0; bus8.A = 0; bus8.B = 0; bus8.qH = 5'd15; bus8.in_tag = 0;
    bus8.out_ready = 1;
    bus0.in_valid = 0; bus0.A = 0; bus0.B = 0; bus0.qH = 5'd15; bus0.in_tag = 0;
    bus0.out_ready = 1;
    bus64.in_valid = 0; bus64.A = 0; bus64.B = 0; bus64.qH = 0; bus64.in_tag = 0;
    bus64.out_ready = 1;
    rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus8.out_valid), 64'd0);
    chk("rst_C",         64'(bus8.C),         64'd0);
    chk("rst_out_tag",   64'(bus8.out_tag),   64'd0);
    chk("rst_in_ready",  64'(bus8.in_ready),  64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // No wrap, with latency check.
    send8(8'd10, 8'd3, 8'h11, 64'd7, w);
    n0 = acc8_cyc;
    drain8("drain_nowrap");
    chk("latency", 64'(out8_cyc[out8_cyc.size()-1] - n0), 64'd3);

    // Wrap and edge cases.
    send8(8'd3,   8'd10,  8'h12, 64'd114, w); drain8("drain_wrap");
    send8(8'd0,   8'd120, 8'h13, 64'd1,   w); drain8("drain_edge0");
    send8(8'd50,  8'd50,  8'h14, 64'd0,   w); drain8("drain_equal");
    send8(8'd120, 8'd0,   8'h15, 64'd120, w); drain8("drain_max");

    // Back-to-back.
    n0 = out8_cyc.size();
    for (int i = 0; i < 8; i++) begin
      a8 = 8'($urandom_range(0, 120));
      b8 = 8'($urandom_range(0, 120));
      send8(a8, b8, 8'h40 + 8'(i), ref_mod(64'(a8), 64'(b8), 64'd121), w);
      chk("b2b_no_wait", 64'(w), 64'd0);
    end
    drain8("drain_b2b");
    chk("b2b_consecutive", 64'(out8_cyc[n0+7] - out8_cyc[n0]), 64'd7);

    // Backpressure.
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = 8'($urandom_range(0, 120));
      bp_b[i] = 8'($urandom_range(0, 120));
    end
    n0 = out8_n;
    bp_idx = 0;
    bus8.out_ready = 1'b0;
    bus8.A = bp_a[0]; bus8.B = bp_b[0]; bus8.in_tag = 8'hB0; bus8.in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bp_step();
      if (c >= 3) begin
        chk("bp_hold_valid", 64'(bus8.out_valid), 64'd1);
        chk("bp_hold_C",     64'(bus8.C),         q8[0].c);
        chk("bp_hold_tag",   64'(bus8.out_tag),   64'(q8[0].tag));
      end
    end
    chk("bp_accepts", 64'(bp_idx), 64'd3);
    chk("bp_full_in_ready", 64'(bus8.in_ready), 64'd0);
    bus8.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_return", 64'(bus8.in_ready), 64'd1);
    for (int g = 0; g < 20 && bp_idx < 5; g++) bp_step();
    bus8.in_valid = 1'b0;
    drain8("drain_bp");
    chk("bp_count", 64'(out8_n - n0), 64'd5);

    // Reset mid-flight.
    bus8.out_ready = 1'b0;
    send8(8'd1, 8'd2, 8'hC0, 64'd120, w);
    send8(8'd5, 8'd2, 8'hC1, 64'd3,   w);
    send8(8'd9, 8'd9, 8'hC2, 64'd0,   w);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 64'(bus8.out_valid), 64'd0);
    chk("rstmid_C",         64'(bus8.C),         64'd0);
    chk("rstmid_out_tag",   64'(bus8.out_tag),   64'd0);
    chk("rstmid_in_ready",  64'(bus8.in_ready),  64'd1);
    q8.delete();
    @(negedge clk) rst_n = 1'b1;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    n0 = out8_n;
    send8(8'd7,  8'd9, 8'hA0, 64'd119, w);
    send8(8'd60, 8'd1, 8'hA1, 64'd59,  w);
    drain8("drain_postrst");
    repeat (5) @(posedge clk);
    #1;
    chk("postrst_count", 64'(out8_n - n0), 64'd2);

    // Combinational configuration.
    bus0.A = 8'd3; bus0.B = 8'd10; bus0.in_tag = 8'h5A; bus0.in_valid = 1'b1;
    bus0.out_ready = 1'b1;
    #1;
    chk("lat0_C",         64'(bus0.C),         64'd114);
    chk("lat0_tag",       64'(bus0.out_tag),   64'h5A);
    chk("lat0_out_valid", 64'(bus0.out_valid), 64'd1);
    chk("lat0_in_ready1", 64'(bus0.in_ready),  64'd1);
    bus0.out_ready = 1'b0;
    #1;
    chk("lat0_in_ready0", 64'(bus0.in_ready),  64'd0);
    for (int i = 0; i < 4; i++) begin
      a8 = 8'($urandom_range(0, 120));
      b8 = 8'($urandom_range(0, 120));
      bus0.A = a8; bus0.B = b8;
      #1;
      chk("lat0_rand_C", 64'(bus0.C), ref_mod(64'(a8), 64'(b8), 64'd121));
    end
    bus0.in_valid = 1'b0;
    #1;
    chk("lat0_idle_valid", 64'(bus0.out_valid), 64'd0);

    // Randomised 64-bit run with random valid/ready.
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            bus64.in_valid = 1'b0;
            @(posedge clk); #1;
            continue;
          end
          qh = {$urandom, $urandom} & {47{1'b1}};
          q  = q_of(qh);
          a  = {$urandom, $urandom} % q;
          b  = {$urandom, $urandom} % q;
          case ($urandom_range(0, 7))
            0: begin a = 64'd0;  b = q - 64'd1; end
            1: begin a = q - 64'd1; b = 64'd0;  end
            2: b = a;
            default: ;
          endcase
          bus64.A = a; bus64.B = b; bus64.qH = qh; bus64.in_tag = 8'(i);
          bus64.in_valid = 1'b1;
          w = 0;
          @(negedge clk);
          while (!bus64.in_ready && w < 200) begin
            w++;
            @(negedge clk);
          end
          if (!bus64.in_ready) begin
            checks++; errors++;
            $display("FAIL rnd_accept_timeout: in_ready got 0, expected 1 within 200 cycles");
          end else begin
            q64.push_back('{ref_mod(a, b, q), 8'(i)});
            sent64++;
          end
          @(posedge clk); #1;
          bus64.in_valid = 1'b0;
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          bus64.out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    bus64.out_ready = 1'b1;
    for (int g = 0; g < 100 && q64.size() != 0; g++) begin
      @(posedge clk); #1;
    end
    chk("rnd_drain", 64'(q64.size()), 64'd0);
    chk("rnd_count", 64'(out64_n), 64'(sent64));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
